step_pulse_ctrl: RTL and testbench

Consumes the two debounced push-button levels and turns them into processor execution control for the MIPS core. Button 0 (step) produces single-cycle step pulses: one per press, with auto-repeat while held. Button 1 (run) toggles free-run mode. Output cpu_ce is the clock enable for the datapath; step_count reports the number of steps issued, for display.

---
 rtl/step_pulse_ctrl.sv | 126 ++++++++++++
 tb/tb_step_pulse_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_ctrl
// Description : Turns debounced step/run button levels into CPU clock-enable
//               control: single steps with auto-repeat, plus free-run toggle.
// Revision    : 1.0 - initial release
// ============================================================================
module step_pulse_ctrl #(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int TMR_W         = 26,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             btn_run,
    output logic             step_pulse,
    output logic             run_mode,
    output logic             cpu_ce,
    output logic [CNT_W-1:0] step_count,
    output logic             busy
);

    localparam logic [TMR_W-1:0] c_HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HELD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               step_q, run_q;
    logic               pulse_q, pulse_d;
    logic               run_mode_q, run_mode_d;

    logic w_step_rise;
    logic w_run_rise;
    logic w_suppress;

    assign w_step_rise = btn_step & ~step_q;
    assign w_run_rise  = btn_run & ~run_q;
    // A run toggle on this very edge must also block a coincident step press.
    assign w_suppress  = run_mode_q | w_run_rise;

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        pulse_d    = 1'b0;
        run_mode_d = run_mode_q ^ w_run_rise;

        if (w_suppress) begin
            state_d = S_IDLE;
            tmr_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_step_rise) begin
                        state_d = S_HELD;
                        tmr_d   = '0;
                        pulse_d = 1'b1;
                    end
                end
                S_HELD: begin
                    if (!btn_step) begin
                        state_d = S_IDLE;
                    end else if (tmr_q == c_HOLD_LAST) begin
                        state_d = S_REPEAT;
                        tmr_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                S_REPEAT: begin
                    if (!btn_step) begin
                        state_d = S_IDLE;
                    end else if (tmr_q == c_REPEAT_LAST) begin
                        tmr_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end
            endcase
        end

        cnt_d = pulse_d ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            cnt_q      <= '0;
            step_q     <= 1'b0;
            run_q      <= 1'b0;
            pulse_q    <= 1'b0;
            run_mode_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            step_q     <= btn_step;
            run_q      <= btn_run;
            pulse_q    <= pulse_d;
            run_mode_q <= run_mode_d;
        end
    end

    assign step_pulse = pulse_q;
    assign run_mode   = run_mode_q;
    assign cpu_ce     = run_mode_q | pulse_q;
    assign step_count = cnt_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_pulse_ctrl
// Description : Scoreboard bench for step_pulse_ctrl (HOLD=8, REPEAT=4, CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_pulse_ctrl;

    localparam int HOLD = 8;
    localparam int REP  = 4;
    localparam int CW   = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          btn_step = 1'b1;
    logic          btn_run  = 1'b1;
    logic          step_pulse;
    logic          run_mode;
    logic          cpu_ce;
    logic [CW-1:0] step_count;
    logic          busy;

    step_pulse_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .TMR_W         (4),
        .CNT_W         (CW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_step   (btn_step),
        .btn_run    (btn_run),
        .step_pulse (step_pulse),
        .run_mode   (run_mode),
        .cpu_ce     (cpu_ce),
        .step_count (step_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          pulse;
        logic          run;
        logic          ce;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: a press is "alive" from its unsuppressed rise until release
    // or suppression; m_h counts held edges after the first pulse.
    bit            m_sq, m_rq, m_run, m_alive;
    int            m_h;
    logic [CW-1:0] m_cnt;

    task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_value("step_pulse", 16'(step_pulse), 16'(e.pulse));
            check_value("run_mode",   16'(run_mode),   16'(e.run));
            check_value("cpu_ce",     16'(cpu_ce),     16'(e.ce));
            check_value("busy",       16'(busy),       16'(e.busy));
            check_value("step_count", 16'(step_count), 16'(e.cnt));
        end
    end

    task automatic model_reset();
        m_sq = 1'b0; m_rq = 1'b0; m_run = 1'b0; m_alive = 1'b0;
        m_h = 0; m_cnt = '0;
    endtask

    task automatic drive(input bit bs, input bit br);
        bit rr, sr, sup, p;
        @(negedge clk);
        btn_step = bs;
        btn_run  = br;
        @(posedge clk);
        rr  = br && !m_rq;
        sr  = bs && !m_sq;
        sup = m_run || rr;
        p   = 1'b0;
        if (sup) begin
            m_alive = 1'b0;
        end else if (m_alive) begin
            if (bs) begin
                m_h++;
                p = (m_h == HOLD) || (m_h > HOLD && ((m_h - HOLD) % REP) == 0);
            end else begin
                m_alive = 1'b0;
            end
        end else if (sr) begin
            m_alive = 1'b1;
            m_h = 0;
            p = 1'b1;
        end
        if (p) m_cnt = m_cnt + 1'b1;
        if (rr) m_run = !m_run;
        m_sq = bs;
        m_rq = br;
        sb_q.push_back({p, m_run, m_run | p, m_alive, m_cnt});
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_zero"}, {11'b0, step_pulse, run_mode, cpu_ce, busy, |step_count}, 16'h0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic pulse_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        // 1. Reset with both buttons high, then release with them still high
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;
        drive(1, 1);
        #1 check_value("rst_rel_run", 16'(run_mode), 16'd1);
        check_value("rst_rel_pulse", 16'(step_pulse), 16'd0);
        drive(0, 0);
        drive(0, 1);
        drive(0, 0);
        drive(0, 0);

        // 2. Single press
        repeat (3) drive(1, 0);
        repeat (3) drive(0, 0);
        #1 check_value("single_cnt", 16'(step_count), 16'd1);
        check_value("single_busy", 16'(busy), 16'd0);

        // 3. Auto-repeat: held through edge 19 after the first pulse
        pulse_reset();
        repeat (20) drive(1, 0);
        repeat (3) drive(0, 0);
        #1 check_value("repeat_cnt", 16'(step_count), 16'd4);

        // Reset during a hold, button still high afterwards
        repeat (3) drive(1, 0);
        pulse_reset();
        drive(1, 0);
        #1 check_value("midhold_pulse", 16'(step_pulse), 16'd1);
        check_value("midhold_cnt", 16'(step_count), 16'd1);
        repeat (2) drive(0, 0);

        // 4. Counter wrap
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 0);
            drive(0, 0);
            if (i == 15) begin
                #1 check_value("wrap16_cnt", 16'(step_count), 16'd0);
            end
        end
        #1 check_value("wrap17_cnt", 16'(step_count), 16'd1);

        // 5. Run mode: presses ignored, press held through run->step gives nothing
        drive(0, 1);
        drive(0, 1);
        drive(0, 0);
        for (int i = 0; i < 2; i++) begin
            repeat (3) drive(1, 0);
            drive(0, 0);
        end
        #1 check_value("run_ce", 16'(cpu_ce), 16'd1);
        check_value("run_cnt", 16'(step_count), 16'd1);
        repeat (2) drive(1, 0);
        drive(1, 1);
        repeat (4) drive(1, 0);
        drive(0, 0);
        #1 check_value("stop_run", 16'(run_mode), 16'd0);
        check_value("stop_ce", 16'(cpu_ce), 16'd0);
        check_value("stop_cnt", 16'(step_count), 16'd1);

        // 6. Simultaneous step and run rises
        drive(0, 0);
        drive(1, 1);
        #1 check_value("sim_run", 16'(run_mode), 16'd1);
        check_value("sim_pulse", 16'(step_pulse), 16'd0);
        check_value("sim_busy", 16'(busy), 16'd0);
        check_value("sim_cnt", 16'(step_count), 16'd1);
        drive(0, 0);
        drive(0, 1);
        drive(0, 0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
